sw_window_ctrl: RTL and testbench
=================================

# sw_window_ctrl

Sequential controller for the 8-bit switch range-detect datapath. It lets the user program a lower and upper bound from the switches, arms detection, and drives `led` only after the switch value has been in range and unchanged for a programmable number of cycles. It counts qualified matches and flags an invalid window. It sits between the board switch/button inputs and the LEDs, and owns one instance of the window comparator.

## Interface
- `WIDTH`, 8: switch/bound width.
- `STABLE_CYCLES`, 4: consecutive in-range, unchanged samples required before a match (legal range 2..255).
- `LO_INIT`, 160: reset value of the lower bound.
- `HI_INIT`, 185: reset value of the upper bound.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state immediately.
- `sw`  in  WIDTH: switch value, already synchronized to `clk`.
- `load_lo`  in  1: one-cycle pulse; latches `sw` into the lower bound.
- `load_hi`  in  1: one-cycle pulse; latches `sw` into the upper bound.
- `arm`  in  1: one-cycle pulse; arms from IDLE, disarms from any other state.
- `led`  out  1: qualified in-range match.
- `led_armed`  out  1: high in ARMED, SETTLE and MATCH.
- `led_fault`  out  1: high in FAULT (lower bound > upper bound at arm).
- `lo_q`  out  WIDTH: current lower bound.
- `hi_q`  out  WIDTH: current upper bound.
- `hits`  out  8: saturating count of entries into MATCH.

## Operation
- In range: `lo_q <= sw <= hi_q`, unsigned and inclusive at both ends.
- State encoding: IDLE, ARMED, SETTLE, MATCH, FAULT. Reset state is IDLE.
- **IDLE**
  - `load_lo` / `load_hi` update the bounds. Loads in any other state are ignored.
  - If `load_lo` and `load_hi` arrive in the same cycle, both bounds take `sw`.
  - On `arm`: if `lo_q <= hi_q`, go to ARMED and clear `hits`; otherwise go to FAULT.
  - Bounds used for this check are the values before any same-cycle load. `arm` has priority over a same-cycle load, and that load is dropped.
- **ARMED**
  - When `sw` is in range: go to SETTLE, capture `ref <= sw`, set `cnt <= 1`.
- **SETTLE**
  - If `sw == ref` and `sw` is in range: `cnt <= cnt + 1`.
  - When `cnt == STABLE_CYCLES-1` and the condition holds: go to MATCH and increment `hits` (saturating at 255).
  - If the condition fails: go to ARMED. Even if the new `sw` is in range, SETTLE is not re-entered until the next edge.
- **MATCH**
  - Stay while `sw` is in range; a changed in-range value does not leave MATCH.
  - When `sw` goes out of range: go to ARMED.
- **FAULT**
  - Only `arm` exits, to IDLE. Loads are ignored.
- `arm` in ARMED, SETTLE or MATCH goes to IDLE. It has priority over every other transition in the same cycle.
- `reset` mid-operation:
  - returns to IDLE;
  - reloads `LO_INIT` / `HI_INIT`;
  - clears `hits`, `cnt` and `ref`.

## Timing
- Every output is a register output or a direct decode of the state register; there is no combinational path from an input to an output.
- Reset values: `led=0`, `led_armed=0`, `led_fault=0`, `lo_q=LO_INIT`, `hi_q=HI_INIT`, `hits=0`.
- Bound loads are visible on `lo_q` / `hi_q` one cycle after the pulse.
- Arm latency: `led_armed` rises the cycle after `arm`.
- Match latency: `led` rises after the `STABLE_CYCLES`-th consecutive qualifying edge, counting the ARMED→SETTLE edge as the first. `hits` updates on that same edge.
- Drop latency: `led` falls on the first edge at which `sw` is sampled out of range, or at which `arm` is sampled.

## Structure
- Shared package `sw_ctrl_pkg` holds:
  - the state enum `win_state_t`;
  - the default constants `LO_INIT_DEF = 8'd160` and `HI_INIT_DEF = 8'd185`;
  - the counter width rule `$clog2(256)`.
- One sub-module: `range_cmp`, purely combinational (`val`, `lo`, `hi` → `in_range`). It is the only place the comparison is made.
- The controller holds:
  - the FSM;
  - the bound registers;
  - `ref` / `cnt`;
  - the `hits` counter.

## Test plan
- Reset defaults, then `sw=170` and `arm`: `led_armed` high the next cycle, `led` high 4 edges after the first in-range sample, `hits=1`.
- Boundaries:
  - `sw=160` and `sw=185` each reach MATCH;
  - `sw=159` and `sw=186` stay in ARMED with `led=0`.
- Settle interruption:
  - `sw=170` for 2 edges, then 171: state returns to ARMED and `led` stays 0;
  - 171 then held for 4 more edges matches, `hits=1`.
- Window reprogramming and fault:
  - `sw=50` + `load_lo`, then `sw=40` + `load_hi`, then `arm` → `led_fault=1`, `led_armed=0`;
  - a second `arm` → IDLE;
  - reload `lo=40`, `hi=50`, `arm` with `sw=45` → match.
- MATCH exit and re-entry:
  - in MATCH, change `sw` 170→180: `led` stays 1;
  - `sw=200`: `led` falls next edge;
  - return to 170 for 4 edges: `hits=2`.
- Priority and reset:
  - `arm` pulse in MATCH → IDLE, `led=0`;
  - `load_lo` during ARMED is ignored (`lo_q` unchanged);
  - async `reset` asserted mid-SETTLE clears all outputs without waiting for a clock edge.

Source files
------------

// File: rtl/sw_ctrl_pkg.sv
// Shared types and constants for the switch window-detect controller.
package sw_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_MATCH  = 3'd3,
    ST_FAULT  = 3'd4
  } win_state_t;

  localparam logic [7:0] LO_INIT_DEF = 8'd160;
  localparam logic [7:0] HI_INIT_DEF = 8'd185;

  // Width of the settle counter and the saturating hit counter.
  localparam int unsigned CNT_W = $clog2(256);

endpackage

// File: rtl/range_cmp.sv
// Inclusive unsigned window comparator: lo <= val <= hi.
module range_cmp #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] val,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  output logic             in_range
);

  assign in_range = (val >= lo) && (val <= hi);

endmodule

// File: rtl/sw_window_ctrl.sv
// Switch window controller: programmable bounds, settle qualification,
// match LED, fault on inverted window and saturating match counter.
module sw_window_ctrl
  import sw_ctrl_pkg::*;
#(
  parameter int unsigned     WIDTH         = 8,
  parameter int unsigned     STABLE_CYCLES = 4,
  parameter logic [WIDTH-1:0] LO_INIT      = LO_INIT_DEF,
  parameter logic [WIDTH-1:0] HI_INIT      = HI_INIT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw,
  input  logic             load_lo,
  input  logic             load_hi,
  input  logic             arm,
  output logic             led,
  output logic             led_armed,
  output logic             led_fault,
  output logic [WIDTH-1:0] lo_q,
  output logic [WIDTH-1:0] hi_q,
  output logic [CNT_W-1:0] hits
);

  win_state_t       r_state;
  win_state_t       w_state_nxt;
  logic [WIDTH-1:0] r_lo, w_lo_nxt;
  logic [WIDTH-1:0] r_hi, w_hi_nxt;
  logic [WIDTH-1:0] r_ref, w_ref_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_hits, w_hits_nxt;
  logic             r_led, r_led_armed, r_led_fault;
  logic [WIDTH-1:0] w_cmp_val;
  logic             w_in_range;
  logic             w_settle_ok;

  // In IDLE the switch value is irrelevant, so the comparator checks lo
  // against the window instead; lo in [lo, hi] is exactly "lo <= hi".
  assign w_cmp_val = (r_state == ST_IDLE) ? r_lo : sw;

  range_cmp #(.WIDTH(WIDTH)) u_range_cmp (
    .val      (w_cmp_val),
    .lo       (r_lo),
    .hi       (r_hi),
    .in_range (w_in_range)
  );

  assign w_settle_ok = w_in_range && (sw == r_ref);

  // Next-state and datapath update decode; arm has priority everywhere.
  always_comb begin
    w_state_nxt = r_state;
    w_lo_nxt    = r_lo;
    w_hi_nxt    = r_hi;
    w_ref_nxt   = r_ref;
    w_cnt_nxt   = r_cnt;
    w_hits_nxt  = r_hits;
    case (r_state)
      ST_IDLE: begin
        if (arm) begin
          if (w_in_range) begin
            w_state_nxt = ST_ARMED;
            w_hits_nxt  = '0;
          end else begin
            w_state_nxt = ST_FAULT;
          end
        end else begin
          if (load_lo) w_lo_nxt = sw;
          if (load_hi) w_hi_nxt = sw;
        end
      end
      ST_ARMED: begin
        if (arm) begin
          w_state_nxt = ST_IDLE;
        end else if (w_in_range) begin
          w_state_nxt = ST_SETTLE;
          w_ref_nxt   = sw;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (arm) begin
          w_state_nxt = ST_IDLE;
        end else if (w_settle_ok) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(STABLE_CYCLES - 1)) begin
            w_state_nxt = ST_MATCH;
            if (r_hits != '1) w_hits_nxt = r_hits + CNT_W'(1);
          end
        end else begin
          w_state_nxt = ST_ARMED;
        end
      end
      ST_MATCH: begin
        if (arm) begin
          w_state_nxt = ST_IDLE;
        end else if (!w_in_range) begin
          w_state_nxt = ST_ARMED;
        end
      end
      ST_FAULT: begin
        if (arm) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, datapath and registered status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_lo        <= LO_INIT;
      r_hi        <= HI_INIT;
      r_ref       <= '0;
      r_cnt       <= '0;
      r_hits      <= '0;
      r_led       <= 1'b0;
      r_led_armed <= 1'b0;
      r_led_fault <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_lo        <= w_lo_nxt;
      r_hi        <= w_hi_nxt;
      r_ref       <= w_ref_nxt;
      r_cnt       <= w_cnt_nxt;
      r_hits      <= w_hits_nxt;
      r_led       <= (w_state_nxt == ST_MATCH);
      r_led_armed <= (w_state_nxt == ST_ARMED) || (w_state_nxt == ST_SETTLE) ||
                     (w_state_nxt == ST_MATCH);
      r_led_fault <= (w_state_nxt == ST_FAULT);
    end
  end

  assign led       = r_led;
  assign led_armed = r_led_armed;
  assign led_fault = r_led_fault;
  assign lo_q      = r_lo;
  assign hi_q      = r_hi;
  assign hits      = r_hits;

endmodule

// File: tb/tb_sw_window_ctrl.sv
// Directed bench for sw_window_ctrl with a streak-based reference model.
module tb_sw_window_ctrl;

  localparam int unsigned STABLE = 4;

  typedef struct packed {
    logic       armed;
    logic       fault;
    logic       match;
    logic [7:0] run;
    logic [7:0] rf;
    logic [7:0] lo;
    logic [7:0] hi;
    logic [7:0] hits;
  } model_t;

  localparam model_t MODEL_RST = '{armed: 1'b0, fault: 1'b0, match: 1'b0,
                                   run: 8'd0, rf: 8'd0, lo: 8'd160,
                                   hi: 8'd185, hits: 8'd0};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] sw = 8'd0;
  logic       load_lo = 1'b0;
  logic       load_hi = 1'b0;
  logic       arm = 1'b0;
  logic       led, led_armed, led_fault;
  logic [7:0] lo_q, hi_q, hits;

  int n_checks = 0;
  int n_errors = 0;

  model_t m;

  sw_window_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .sw        (sw),
    .load_lo   (load_lo),
    .load_hi   (load_hi),
    .arm       (arm),
    .led       (led),
    .led_armed (led_armed),
    .led_fault (led_fault),
    .lo_q      (lo_q),
    .hi_q      (hi_q),
    .hits      (hits)
  );

  always #5 clk = ~clk;

  // Model: a match is a streak of STABLE identical in-range samples while
  // armed; a broken streak cannot restart on the edge that broke it.
  function automatic model_t model_next(input model_t c, input logic [7:0] s,
                                        input logic ll, input logic lh,
                                        input logic a);
    model_t n;
    logic   inr;
    logic   idle;
    n    = c;
    inr  = (s >= c.lo) && (s <= c.hi);
    idle = !c.armed && !c.fault;
    if (a) begin
      if (idle) begin
        if (c.lo <= c.hi) begin
          n.armed = 1'b1;
          n.hits  = 8'd0;
        end else begin
          n.fault = 1'b1;
        end
      end else begin
        n.armed = 1'b0;
        n.fault = 1'b0;
      end
      n.match = 1'b0;
      n.run   = 8'd0;
    end else if (idle) begin
      if (ll) n.lo = s;
      if (lh) n.hi = s;
    end else if (c.armed) begin
      if (c.match) begin
        if (!inr) begin
          n.match = 1'b0;
          n.run   = 8'd0;
        end
      end else if (c.run != 8'd0) begin
        if (inr && s == c.rf) begin
          n.run = c.run + 8'd1;
          if (int'(n.run) == STABLE) begin
            n.match = 1'b1;
            if (c.hits != 8'd255) n.hits = c.hits + 8'd1;
          end
        end else begin
          n.run = 8'd0;
        end
      end else if (inr) begin
        n.run = 8'd1;
        n.rf  = s;
      end
    end
    return n;
  endfunction

  // Reference model state, reset asynchronously like the design.
  always @(posedge clk or posedge reset) begin
    if (reset) m <= MODEL_RST;
    else       m <= model_next(m, sw, load_lo, load_hi, arm);
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("model_led",       32'(led),       32'(m.match));
    chk("model_led_armed", 32'(led_armed), 32'(m.armed));
    chk("model_led_fault", 32'(led_fault), 32'(m.fault));
    chk("model_lo_q",      32'(lo_q),      32'(m.lo));
    chk("model_hi_q",      32'(hi_q),      32'(m.hi));
    chk("model_hits",      32'(hits),      32'(m.hits));
  endtask

  // One clock cycle: drive at negedge, let the edge happen, compare at negedge.
  task automatic cyc(input logic [7:0] s, input logic ll, input logic lh,
                     input logic a);
    sw      = s;
    load_lo = ll;
    load_hi = lh;
    arm     = a;
    @(posedge clk);
    @(negedge clk);
    load_lo = 1'b0;
    load_hi = 1'b0;
    arm     = 1'b0;
    cmp_model();
  endtask

  task automatic hold(input logic [7:0] s, input int n);
    for (int i = 0; i < n; i++) cyc(s, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    cmp_model();
    chk("rst_lo_q", 32'(lo_q), 32'd160);
    chk("rst_hi_q", 32'(hi_q), 32'd185);
    chk("rst_hits", 32'(hits), 32'd0);
    chk("rst_led_armed", 32'(led_armed), 32'd0);

    // Basic arm and match
    cyc(8'd170, 1'b0, 1'b0, 1'b1);
    chk("arm_latency", 32'(led_armed), 32'd1);
    hold(8'd170, 3);
    chk("match_not_early", 32'(led), 32'd0);
    hold(8'd170, 1);
    chk("match_latency", 32'(led), 32'd1);
    chk("match_hits1", 32'(hits), 32'd1);

    // Boundaries
    cyc(8'd200, 1'b0, 1'b0, 1'b0);
    hold(8'd160, 4);
    chk("bound_lo_match", 32'(led), 32'd1);
    cyc(8'd200, 1'b0, 1'b0, 1'b0);
    hold(8'd185, 4);
    chk("bound_hi_match", 32'(led), 32'd1);
    cyc(8'd200, 1'b0, 1'b0, 1'b0);
    hold(8'd159, 6);
    chk("below_lo_led", 32'(led), 32'd0);
    hold(8'd186, 6);
    chk("above_hi_led", 32'(led), 32'd0);
    chk("above_hi_armed", 32'(led_armed), 32'd1);
    chk("bound_hits3", 32'(hits), 32'd3);

    // Settle interruption
    cyc(8'd200, 1'b0, 1'b0, 1'b1);
    cyc(8'd200, 1'b0, 1'b0, 1'b1);
    hold(8'd170, 2);
    cyc(8'd171, 1'b0, 1'b0, 1'b0);
    chk("interrupt_led", 32'(led), 32'd0);
    hold(8'd171, 3);
    chk("interrupt_restart_led", 32'(led), 32'd0);
    hold(8'd171, 1);
    chk("interrupt_match", 32'(led), 32'd1);
    chk("interrupt_hits", 32'(hits), 32'd1);

    // Reprogramming and fault
    cyc(8'd0, 1'b0, 1'b0, 1'b1);
    cyc(8'd50, 1'b1, 1'b0, 1'b0);
    chk("load_lo_50", 32'(lo_q), 32'd50);
    cyc(8'd40, 1'b0, 1'b1, 1'b0);
    chk("load_hi_40", 32'(hi_q), 32'd40);
    cyc(8'd40, 1'b0, 1'b0, 1'b1);
    chk("fault_flag", 32'(led_fault), 32'd1);
    chk("fault_not_armed", 32'(led_armed), 32'd0);
    cyc(8'd0, 1'b0, 1'b0, 1'b1);
    chk("fault_exit", 32'(led_fault), 32'd0);
    cyc(8'd40, 1'b1, 1'b0, 1'b0);
    cyc(8'd50, 1'b0, 1'b1, 1'b0);
    cyc(8'd45, 1'b0, 1'b0, 1'b1);
    hold(8'd45, 4);
    chk("low_window_match", 32'(led), 32'd1);

    // MATCH exit and re-entry
    cyc(8'd0, 1'b0, 1'b0, 1'b1);
    cyc(8'd160, 1'b1, 1'b0, 1'b0);
    cyc(8'd185, 1'b0, 1'b1, 1'b0);
    cyc(8'd170, 1'b0, 1'b0, 1'b1);
    hold(8'd170, 4);
    cyc(8'd180, 1'b0, 1'b0, 1'b0);
    chk("match_value_change", 32'(led), 32'd1);
    cyc(8'd200, 1'b0, 1'b0, 1'b0);
    chk("match_drop", 32'(led), 32'd0);
    hold(8'd170, 4);
    chk("reentry_led", 32'(led), 32'd1);
    chk("reentry_hits2", 32'(hits), 32'd2);

    // Priority and reset
    cyc(8'd170, 1'b0, 1'b0, 1'b1);
    chk("arm_in_match_led", 32'(led), 32'd0);
    chk("arm_in_match_idle", 32'(led_armed), 32'd0);
    cyc(8'd165, 1'b1, 1'b0, 1'b0);
    chk("idle_load_lo", 32'(lo_q), 32'd165);
    cyc(8'd170, 1'b0, 1'b1, 1'b1);
    chk("arm_drops_load", 32'(hi_q), 32'd185);
    cyc(8'd100, 1'b1, 1'b0, 1'b0);
    chk("armed_load_ignored", 32'(lo_q), 32'd165);
    hold(8'd170, 4);
    chk("pre_reset_hits", 32'(hits), 32'd1);
    cyc(8'd200, 1'b0, 1'b0, 1'b0);
    hold(8'd170, 2);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_led_armed", 32'(led_armed), 32'd0);
    chk("async_rst_led", 32'(led), 32'd0);
    chk("async_rst_hits", 32'(hits), 32'd0);
    chk("async_rst_lo_q", 32'(lo_q), 32'd160);
    chk("async_rst_hi_q", 32'(hi_q), 32'd185);
    @(negedge clk);
    cmp_model();
    reset = 1'b0;
    hold(8'd170, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
